branch_resolve_queue: RTL and testbench

In-order queue for branch predictions that are still in flight. It sits directly downstream of the tournament predictor. Each cycle it can capture the fetch PC and the predicted direction, and later compares that prediction against the outcome resolved in execute. It then emits a registered training/update record and a one-cycle mispredict pulse that flushes all younger queued predictions.

---
 rtl/branch_resolve_queue.sv | 120 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; resolves the oldest against execute outcome.
// Optional BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue #(
  parameter int unsigned PC_WIDTH = 12,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_valid,
  input  logic [PC_WIDTH-1:0]          push_pc,
  input  logic                         push_pred,
  output logic                         push_ready,
  input  logic                         resolve_valid,
  input  logic                         resolve_taken,
  output logic                         resolve_ready,
  output logic                         update_valid,
  output logic [PC_WIDTH-1:0]          update_pc,
  output logic                         update_taken,
  output logic                         mispredict,
`ifdef BRQ_STATS_EN
  output logic [15:0]                  stat_resolved,
  output logic [15:0]                  stat_mispred,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic                pred_mem [DEPTH];
  logic [AW-1:0]       head, tail;
  logic                push_fire, pop_fire, miss;

  assign push_fire = push_valid & push_ready;
  assign pop_fire  = resolve_valid & resolve_ready;
  assign miss      = pop_fire & (pred_mem[head] != resolve_taken);

  // Control state register
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (miss) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Handshake readiness comes from registered occupancy only; held low while in reset
  always_comb begin
    push_ready    = 1'b0;
    resolve_ready = 1'b0;
    if (!reset && state == RUN) begin
      push_ready    = (count != CW'(DEPTH));
      resolve_ready = (count != CW'(0));
    end
  end

  // Storage is not reset; validity is carried by count
  always_ff @(posedge clock) begin
    if (push_fire && !miss) begin
      pc_mem[tail]   <= push_pc;
      pred_mem[tail] <= push_pred;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      update_valid <= 1'b0;
      update_pc    <= '0;
      update_taken <= 1'b0;
      mispredict   <= 1'b0;
    end else begin
      update_valid <= pop_fire;
      mispredict   <= miss;
      if (pop_fire) begin
        update_pc    <= pc_mem[head];
        update_taken <= resolve_taken;
      end
      // A wrong prediction discards every younger entry and any same-cycle push
      if (miss) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_fire) tail <= tail + AW'(1);
        if (pop_fire)  head <= head + AW'(1);
        case ({push_fire, pop_fire})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop_fire && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (miss && stat_mispred != 16'hFFFF)      stat_mispred  <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int unsigned PC_WIDTH = 12;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned CW       = $clog2(DEPTH+1);

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                push_valid = 1'b0;
  logic [PC_WIDTH-1:0] push_pc = '0;
  logic                push_pred = 1'b0;
  logic                push_ready;
  logic                resolve_valid = 1'b0;
  logic                resolve_taken = 1'b0;
  logic                resolve_ready;
  logic                update_valid;
  logic [PC_WIDTH-1:0] update_pc;
  logic                update_taken;
  logic                mispredict;
  logic [CW-1:0]       count;
`ifdef BRQ_STATS_EN
  logic [15:0]         stat_resolved;
  logic [15:0]         stat_mispred;
`endif

  branch_resolve_queue #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred), .push_ready(push_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .mispredict(mispredict),
`ifdef BRQ_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
    .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PC_WIDTH-1:0] pc;
    logic                pred;
  } entry_t;

  entry_t              m_q[$];
  logic                m_flush = 1'b0;
  logic                m_uv = 1'b0, m_ut = 1'b0, m_mp = 1'b0;
  logic [PC_WIDTH-1:0] m_upc = '0;
  int                  m_sr = 0, m_sm = 0;
  int                  checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic rst, input logic pv, input logic [PC_WIDTH-1:0] pc,
                      input logic pred, input logic rv, input logic rt);
    logic   pr, rr;
    entry_t e;
    reset = rst; push_valid = pv; push_pc = pc; push_pred = pred;
    resolve_valid = rv; resolve_taken = rt;
    pr = !rst && !m_flush && (m_q.size() < DEPTH);
    rr = !rst && !m_flush && (m_q.size() > 0);
    if (rst) begin
      m_q.delete();
      m_flush = 1'b0; m_uv = 1'b0; m_upc = '0; m_ut = 1'b0; m_mp = 1'b0;
      m_sr = 0; m_sm = 0;
    end else begin
      m_uv = rv && rr;
      m_mp = 1'b0;
      if (m_uv) begin
        e = m_q.pop_front();
        m_upc = e.pc;
        m_ut  = rt;
        m_mp  = (e.pred != rt);
        if (m_sr < 16'hFFFF) m_sr++;
        if (m_mp && m_sm < 16'hFFFF) m_sm++;
      end
      if (m_mp) m_q.delete();
      else if (pv && pr) begin
        e.pc = pc; e.pred = pred;
        m_q.push_back(e);
      end
      m_flush = m_mp;
    end
    @(posedge clock);
    @(negedge clock);
    check("count", 32'(count), 32'(m_q.size()));
    check("push_ready", 32'(push_ready), 32'(!rst && !m_flush && m_q.size() < DEPTH));
    check("resolve_ready", 32'(resolve_ready), 32'(!rst && !m_flush && m_q.size() > 0));
    check("update_valid", 32'(update_valid), 32'(m_uv));
    check("mispredict", 32'(mispredict), 32'(m_mp));
    check("update_pc", 32'(update_pc), 32'(m_upc));
    check("update_taken", 32'(update_taken), 32'(m_ut));
`ifdef BRQ_STATS_EN
    check("stat_resolved", 32'(stat_resolved), 32'(m_sr));
    check("stat_mispred", 32'(stat_mispred), 32'(m_sm));
`endif
  endtask

  function automatic logic head_pred();
    return (m_q.size() > 0) ? m_q[0].pred : 1'b0;
  endfunction

  initial begin
    logic rt;
    @(negedge clock);
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    check("reset_push_ready", 32'(push_ready), 32'd0);

    // Fill to full, then a refused ninth push
    for (int i = 0; i < 8; i++) step(0, 1, PC_WIDTH'(12'h010 + i), (i % 2 == 0), 0, 0);
    check("full_count", 32'(count), 32'd8);
    step(0, 1, 12'h0FF, 1, 0, 0);
    check("ninth_push_ignored", 32'(count), 32'd8);

    // Drain with correct outcomes
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, 0, 1, head_pred());
      check("drain_pc", 32'(update_pc), 32'(12'h010 + i));
    end
    check("drain_empty", 32'(count), 32'd0);

    // Mispredict with a simultaneous push
    step(0, 1, 12'h020, 1, 0, 0);
    step(0, 1, 12'h021, 0, 0, 0);
    step(0, 1, 12'h022, 1, 0, 0);
    step(0, 1, 12'h030, 0, 1, 0);
    check("flush_mispredict", 32'(mispredict), 32'd1);
    check("flush_pc", 32'(update_pc), 32'h020);
    check("flush_count", 32'(count), 32'd0);
    check("flush_push_ready", 32'(push_ready), 32'd0);
    step(0, 0, '0, 0, 0, 0);
    check("after_flush_ready", 32'(push_ready), 32'd1);

    // Steady-state push+resolve at occupancy 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(0, 1, PC_WIDTH'($urandom), 1'($urandom), 0, 0);
    for (int i = 0; i < 100; i++) step(0, 1, PC_WIDTH'($urandom), 1'($urandom), 1, head_pred());
    check("wrap_count", 32'(count), 32'd5);

    // Drain, resolve on empty, then reset with entries queued
    while (m_q.size() > 0) step(0, 0, '0, 0, 1, head_pred());
    step(0, 0, '0, 0, 1, 1);
    check("empty_resolve", 32'(update_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, PC_WIDTH'(12'h040 + i), 1, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    check("reset_count", 32'(count), 32'd0);
    step(0, 0, '0, 0, 0, 0);

    // Random traffic with mostly-correct predictions and rare resets
    for (int i = 0; i < 3000; i++) begin
      rt = ($urandom_range(0, 99) < 85) ? head_pred() : 1'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 65,
           PC_WIDTH'($urandom), 1'($urandom), $urandom_range(0, 99) < 60, rt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
